// File: rtl/ddr3_cmd_scheduler.sv
// Open-page command scheduler for one x16 DDR3 device (8 banks).
// Ports: i_ck/i_rst clock and sync reset; i_init_done gates all commands;
//   i_req_* request handshake (o_req_ready); o_rd_issue/o_wr_issue pulse
//   with RD/WR on the pins; o_ref_overflow sticky refresh overrun;
//   o_cke, o_csbar/o_rasbar/o_casbar/o_webar, o_ba, o_a registered pins.
module ddr3_cmd_scheduler #(
  parameter int T_RCD  = 7,
  parameter int T_RP   = 7,
  parameter int T_RAS  = 20,
  parameter int T_WR   = 14,
  parameter int T_CCD  = 4,
  parameter int T_RFC  = 59,
  parameter int T_REFI = 4160
) (
  input  logic        i_ck,
  input  logic        i_rst,
  input  logic        i_init_done,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_write,
  input  logic [2:0]  i_req_bank,
  input  logic [12:0] i_req_row,
  input  logic [9:0]  i_req_col,
  output logic        o_rd_issue,
  output logic        o_wr_issue,
  output logic        o_ref_overflow,
  output logic        o_cke,
  output logic        o_csbar,
  output logic        o_rasbar,
  output logic        o_casbar,
  output logic        o_webar,
  output logic [2:0]  o_ba,
  output logic [12:0] o_a
);

  localparam int TW = $clog2(T_RCD + T_RP + T_RAS + T_WR
                             + T_CCD + T_RFC + 1);
  localparam int RW = $clog2(T_REFI);

  localparam logic [3:0] C_DES = 4'b1111;
  localparam logic [3:0] C_NOP = 4'b0111;
  localparam logic [3:0] C_ACT = 4'b0011;
  localparam logic [3:0] C_RD  = 4'b0101;
  localparam logic [3:0] C_WR  = 4'b0100;
  localparam logic [3:0] C_PRE = 4'b0010;
  localparam logic [3:0] C_REF = 4'b0001;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE_W,
    S_ACT_W,
    S_COL_W,
    S_RPRE,
    S_REF,
    S_RFC_W
  } state_t;

  state_t          r_state;
  logic [TW-1:0]   r_rcd;
  logic [TW-1:0]   r_rp;
  logic [TW-1:0]   r_ccd;
  logic [TW-1:0]   r_rfc;
  logic [TW-1:0]   r_ras [8];
  logic [TW-1:0]   r_wrr [8];
  logic [7:0]      r_open;
  logic [12:0]     r_orow [8];
  logic [RW-1:0]   r_refc;
  logic            r_pend;
  logic            r_ovf;
  logic            r_wr_q;
  logic [2:0]      r_bank;
  logic [12:0]     r_row;
  logic [9:0]      r_col;
  logic            r_cke;
  logic            r_rdp;
  logic            r_wrp;
  logic [3:0]      r_cmd;
  logic [2:0]      r_ba;
  logic [12:0]     r_a;

  logic            w_exp;
  logic            w_ready;
  logic            w_acc;
  logic            w_hit;
  logic            w_tgt_free;
  logic            w_all_free;
  logic            w_col_go;
  logic            w_cw;
  logic [2:0]      w_cb;
  logic [9:0]      w_cc;

  // Refresh interval expires on the last count of the interval.
  assign w_exp   = i_init_done && (r_refc == RW'(T_REFI - 1));
  // An expiry this cycle blocks acceptance so refresh wins the tie.
  assign w_ready = r_cke && i_init_done && (r_state == S_IDLE)
                   && !r_pend && !w_exp;
  assign w_acc   = i_req_valid && w_ready;
  assign w_hit   = r_open[i_req_bank]
                   && (r_orow[i_req_bank] == i_req_row);
  assign w_tgt_free = (r_ras[r_bank] == '0) && (r_wrr[r_bank] == '0);

  always_comb begin
    w_all_free = 1'b1;
    for (int b = 0; b < 8; b++) begin
      if (r_ras[b] != '0 || r_wrr[b] != '0) w_all_free = 1'b0;
    end
  end

  // Column command either straight from an idle hit or after COL_W.
  always_comb begin
    w_col_go = 1'b0;
    w_cw     = r_wr_q;
    w_cb     = r_bank;
    w_cc     = r_col;
    if (r_state == S_IDLE) begin
      w_cw     = i_req_write;
      w_cb     = i_req_bank;
      w_cc     = i_req_col;
      w_col_go = w_acc && w_hit && (r_ccd == '0);
    end else if (r_state == S_COL_W) begin
      w_col_go = (r_rcd == '0) && (r_ccd == '0);
    end
  end

  always_ff @(posedge i_ck) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_rcd   <= '0;
      r_rp    <= '0;
      r_ccd   <= '0;
      r_rfc   <= '0;
      for (int b = 0; b < 8; b++) begin
        r_ras[b]  <= '0;
        r_wrr[b]  <= '0;
        r_orow[b] <= '0;
      end
      r_open  <= '0;
      r_refc  <= '0;
      r_pend  <= 1'b0;
      r_ovf   <= 1'b0;
      r_wr_q  <= 1'b0;
      r_bank  <= '0;
      r_row   <= '0;
      r_col   <= '0;
      r_cke   <= 1'b0;
      r_rdp   <= 1'b0;
      r_wrp   <= 1'b0;
      r_cmd   <= C_DES;
      r_ba    <= '0;
      r_a     <= '0;
    end else begin
      r_cke <= 1'b1;
      r_cmd <= C_NOP;
      r_rdp <= 1'b0;
      r_wrp <= 1'b0;

      // Timers hold T-1 after their command; zero means satisfied.
      if (r_rcd != '0) r_rcd <= r_rcd - TW'(1);
      if (r_rp  != '0) r_rp  <= r_rp  - TW'(1);
      if (r_ccd != '0) r_ccd <= r_ccd - TW'(1);
      if (r_rfc != '0) r_rfc <= r_rfc - TW'(1);
      for (int b = 0; b < 8; b++) begin
        if (r_ras[b] != '0) r_ras[b] <= r_ras[b] - TW'(1);
        if (r_wrr[b] != '0) r_wrr[b] <= r_wrr[b] - TW'(1);
      end

      if (i_init_done) begin
        if (w_exp) begin
          r_refc <= '0;
          r_pend <= 1'b1;
          if (r_pend) r_ovf <= 1'b1;
        end else begin
          r_refc <= r_refc + RW'(1);
        end
      end

      unique case (r_state)
        S_IDLE: begin
          if (r_pend && i_init_done) begin
            r_state <= (r_open != '0) ? S_RPRE : S_REF;
          end else if (w_acc) begin
            r_wr_q <= i_req_write;
            r_bank <= i_req_bank;
            r_row  <= i_req_row;
            r_col  <= i_req_col;
            if (w_hit) begin
              if (r_ccd != '0) r_state <= S_COL_W;
            end else if (r_open[i_req_bank]) begin
              r_state <= S_PRE_W;
            end else begin
              r_state <= S_ACT_W;
            end
          end
        end
        S_PRE_W: begin
          if (w_tgt_free) begin
            r_cmd          <= C_PRE;
            r_ba           <= r_bank;
            r_a            <= '0;
            r_open[r_bank] <= 1'b0;
            r_rp           <= TW'(T_RP - 1);
            r_state        <= S_ACT_W;
          end
        end
        S_ACT_W: begin
          if (r_rp == '0) begin
            r_cmd          <= C_ACT;
            r_ba           <= r_bank;
            r_a            <= r_row;
            r_open[r_bank] <= 1'b1;
            r_orow[r_bank] <= r_row;
            r_rcd          <= TW'(T_RCD - 1);
            r_ras[r_bank]  <= TW'(T_RAS - 1);
            r_state        <= S_COL_W;
          end
        end
        S_COL_W: begin
        end
        S_RPRE: begin
          if (w_all_free) begin
            r_cmd   <= C_PRE;
            r_a     <= 13'h0400;
            r_open  <= '0;
            r_rp    <= TW'(T_RP - 1);
            r_state <= S_REF;
          end
        end
        S_REF: begin
          if (r_rp == '0) begin
            r_cmd   <= C_REF;
            r_open  <= '0;
            r_rfc   <= TW'(T_RFC - 1);
            r_state <= S_RFC_W;
          end
        end
        S_RFC_W: begin
          if (r_rfc == '0) begin
            // A fresh expiry on this cycle keeps refresh pending.
            r_pend  <= w_exp;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_col_go) begin
        r_cmd   <= w_cw ? C_WR : C_RD;
        r_ba    <= w_cb;
        r_a     <= {1'b1, 2'b00, w_cc};
        r_ccd   <= TW'(T_CCD - 1);
        r_wrp   <= w_cw;
        r_rdp   <= !w_cw;
        if (w_cw) r_wrr[w_cb] <= TW'(T_WR - 1);
        r_state <= S_IDLE;
      end
    end
  end

  assign o_req_ready    = w_ready;
  assign o_rd_issue     = r_rdp;
  assign o_wr_issue     = r_wrp;
  assign o_ref_overflow = r_ovf;
  assign o_cke          = r_cke;
  assign o_csbar        = r_cmd[3];
  assign o_rasbar       = r_cmd[2];
  assign o_casbar       = r_cmd[1];
  assign o_webar        = r_cmd[0];
  assign o_ba           = r_ba;
  assign o_a            = r_a;

endmodule
